// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, command constants and parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_ACK
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - ps2c synchroniser, glitch filter and falling-edge pulse
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic c_in,
  output logic fall_edge
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  f_c_q, f_c_d;

  // Filtered clock only changes once the whole sample window agrees; otherwise it holds
  always_comb begin
    sync_d = {sync_q[0], c_in};
    filt_d = {filt_q[FILTER_LEN-2:0], sync_q[1]};
    f_c_d  = f_c_q;
    if (&filt_q) begin
      f_c_d = 1'b1;
    end else if (~|filt_q) begin
      f_c_d = 1'b0;
    end
    fall_edge = f_c_q & ~f_c_d;
  end

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      filt_q <= '1;
      f_c_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      f_c_q  <= f_c_d;
    end
  end

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command transmitter with ack check and timeout
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       rx_en,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  // One counter serves both the RTS inhibit and the inter-edge timeout
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  tx_state_e     state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    dsync_q, dsync_d;
  logic          fall_edge;
  logic          c_oe, d_oe;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .c_in     (ps2c),
    .fall_edge(fall_edge)
  );

  assign ps2c = c_oe ? 1'b0 : 1'bz;
  assign ps2d = d_oe ? 1'b0 : 1'bz;

  assign tx_idle      = (state_q == ST_IDLE);
  assign rx_en        = (state_q == ST_IDLE);
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

  // Frame sequencing, line drive and tick generation; timeout overrides any state after the case
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    c_oe    = 1'b0;
    d_oe    = 1'b0;
    dsync_d = {dsync_q[0], ps2d};

    case (state_q)
      ST_IDLE: begin
        if (wr_ps2) begin
          shift_d = {odd_parity(din), din};
          n_d     = 4'd0;
          cnt_d   = '0;
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        c_oe = 1'b1;
        if (cnt_q == INH_LAST) begin
          d_oe    = 1'b1;
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_START: begin
        d_oe = 1'b1;
        if (fall_edge) begin
          n_d     = 4'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        d_oe = ~shift_q[0];
        if (fall_edge) begin
          if (n_q == 4'd8) begin
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b1, shift_q[8:1]};
            n_d     = n_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (fall_edge) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (fall_edge) begin
          if (!dsync_q[1]) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q inside {ST_START, ST_DATA, ST_STOP, ST_ACK}) begin
      cnt_d = fall_edge ? '0 : cnt_q + CW'(1);
      if (cnt_d == TMO_LAST) begin
        done_d  = 1'b0;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // State, datapath and tick registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dsync_q <= '1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dsync_q <= dsync_d;
    end
  end

endmodule
